divider_32: RTL and testbench
=============================

# divider_32

Iterative RV32M divider executing DIV, DIVU, REM and REMU. It produces one quotient bit per clock using restoring shift-subtract. It sits in the muldiv unit beside the combinational multiplier and shares that unit's operand and result buses. The core stalls on `busy_o` and captures `result_o` when `done_o` pulses.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk_i` input 1: single clock. All state updates on the rising edge.
- `reset_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: request a division; sampled only in IDLE.
- `op_i` input 2: equals funct3[1:0]. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend_i` input 32: rs1. Captured on the accepted start.
- `divisor_i` input 32: rs2. Captured on the accepted start.
- `flush_i` input 1: pipeline flush; aborts any in-flight operation.
- `busy_o` output 1: high from the cycle after accept until `done_o` has pulsed.
- `done_o` output 1: single-cycle pulse; `result_o` is valid in that cycle.
- `result_o` output 32: quotient or remainder. Held stable until the next accept.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, on `start_i`: latch `op_i` and the operands.
  - Signed ops: record the quotient sign (sign(rs1) XOR sign(rs2)) and the remainder sign (sign(rs1)); take absolute values.
- Special cases from IDLE go directly to DONE:
  - Divisor zero: quotient 0xFFFFFFFF for DIV and DIVU; remainder = dividend for REM and REMU.
  - Signed overflow, DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Otherwise go to CALC with the 5-bit counter at 0.
- CALC, each cycle:
  - {rem, quo} shifts left one bit.
  - Trial difference = rem − |divisor|, computed 33-bit.
  - If non-negative: rem takes the difference and the quotient LSB is 1. Otherwise rem is kept and the LSB is 0.
  - Counter increments. Counter at 31 → FIX.
- FIX: apply the sign correction (two's-complement negate) to the selected result, then select the quotient or remainder by `op_i[1]` into `result_o` → DONE.
- DONE: `done_o` = 1 for one cycle → IDLE.
- `start_i` while busy is ignored; no queueing.
- `flush_i` in any state: next state IDLE, `busy_o` low next cycle, no `done_o`. `result_o` keeps its previous value.
- `flush_i` and `start_i` in the same cycle while in IDLE: flush wins; the start is dropped.
- A new start is accepted in the IDLE cycle directly following DONE.
- Absolute value of 0x80000000 is 0x80000000, treated as unsigned. The 33-bit trial subtraction keeps this exact.

## Timing
- Reset values: state IDLE; `busy_o` 0; `done_o` 0; `result_o` 0x00000000; counter 0; all internal registers 0.
- Reset asserted mid-operation: the operation is abandoned immediately and asynchronously; no `done_o`.
- Normal path, accept at edge 0:
  - CALC occupies edges 1–32.
  - FIX at edge 33.
  - `done_o` high in the cycle after edge 34, for a latency of 34 cycles.
- Special-case path: `done_o` high after edge 1, latency 1 cycle.
- `busy_o` is high from edge 0 up to the edge that ends DONE, including the DONE cycle.
- No combinational path from any input to any output.

## Structure
- `muldiv_pkg` holds:
  - the op encodings `OP_DIV`, `OP_DIVU`, `OP_REM`, `OP_REMU`;
  - the state encoding;
  - `XLEN`;
  - the constants `DIV_ZERO_Q` (0xFFFFFFFF) and `INT_MIN` (0x80000000).
- One sub-module, `div_step`: combinational restoring step. Inputs are the partial remainder, the incoming dividend bit and |divisor|. Outputs are the next remainder and the quotient bit.
- Everything else stays in `divider_32`: FSM, counter, sign handling, special-case detect.

## Test plan
- DIVU 100 / 7 → `done_o` at cycle 34, `result_o` = 14. REMU with the same operands → 2.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1); the remainder takes the dividend's sign.
- DIV 5 / 0 → 0xFFFFFFFF at cycle 1. REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Start DIVU 0xFFFFFFFF / 1:
  - assert `start_i` with different operands at cycle 10 → ignored; result 0xFFFFFFFF at cycle 34;
  - back-to-back start in the following IDLE cycle → accepted.
- Start DIV, assert `flush_i` at cycle 15 → `busy_o` low at cycle 16, no `done_o` within 40 cycles, `result_o` unchanged.
- Same abort repeated with asynchronous `reset_i` mid-CALC → outputs go to reset values without waiting for a clock edge.
- Random signed and unsigned operands, including 0, 1, −1 and INT_MIN, checked against a reference model.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv unit: op codes, divider states
// and the architectural constants of RV32M division.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in a dividend bit and
// subtract the divisor if the partial remainder allows it.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0]   shifted;
    logic [W+1:0] diff;

    // Extra top bit keeps the borrow exact even for |divisor| = 2^31 or 2^32-1
    assign shifted = {rem_i, bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_i};
    assign q_o     = ~diff[W+1];
    assign rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/divider_32.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per
// clock, with divide-by-zero and signed-overflow short cuts.
module divider_32 #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    import muldiv_pkg::*;

    div_state_e      state_q;
    logic [1:0]      op_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] result_q;
    logic            qneg_q;
    logic            rneg_q;
    logic            busy_q;
    logic            done_q;

    logic            sgn_op;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            ovf;
    logic [XLEN-1:0] rem_d;
    logic            qbit_d;
    logic [XLEN-1:0] quo_d;

    assign sgn_op = ~op_i[0];
    assign abs_a  = (sgn_op && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    assign abs_b  = (sgn_op && divisor_i[XLEN-1]) ? -divisor_i : divisor_i;
    assign ovf    = sgn_op && (dividend_i == INT_MIN) && (&divisor_i);

    div_step #(.W(XLEN)) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[XLEN-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .q_o   (qbit_d)
    );

    assign quo_d = {quo_q[XLEN-2:0], qbit_d};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q   <= op_i;
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        quo_q  <= abs_a;
                        dvs_q  <= abs_b;
                        qneg_q <= sgn_op & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        rneg_q <= sgn_op & dividend_i[XLEN-1];
                        if (divisor_i == '0) begin
                            res_q   <= op_i[1] ? dividend_i : DIV_ZERO_Q;
                            state_q <= S_DONE;
                        end else if (ovf) begin
                            res_q   <= op_i[1] ? '0 : INT_MIN;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (op_q[1]) res_q <= rneg_q ? -rem_q : rem_q;
                    else         res_q <= qneg_q ? -quo_q : quo_q;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    result_q <= res_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_divider_32.sv
// Directed and model-checked stimulus for divider_32, covering
// latency, special cases, ignored starts, flush and async reset.
module tb_divider_32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int n_cmp = 0;
    int n_bad = 0;

    divider_32 #(.XLEN(32)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .op_i       (op),
        .dividend_i (dvd),
        .divisor_i  (dvs),
        .flush_i    (flush),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return o[1] ? 32'h0 : 32'h8000_0000;
            if (o[1]) return sa % sb;
            return sa / sb;
        end
        if (o[1]) return a % b;
        return a / b;
    endfunction

    // Accept at edge 0, then count edges until done_o is seen (bounded)
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int n;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        dvd   = a;
        dvs   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check(tag, res, exp);
        check({tag, "_nbusy"}, {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    logic [31:0] pool[8];
    logic [31:0] held;
    int          n;
    logic        seen;

    initial begin
        vecs[0]  = '{"divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34};
        vecs[1]  = '{"remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34};
        vecs[2]  = '{"div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34};
        vecs[3]  = '{"rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{"div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
        vecs[5]  = '{"remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1};
        vecs[6]  = '{"div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{"rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1};
        vecs[8]  = '{"divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34};
        vecs[9]  = '{"rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34};
        vecs[10] = '{"div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 34};
        vecs[11] = '{"remu_max_16", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 34};
        pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                 32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFE, 32'd10};

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        dvd   = '0;
        dvs   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_res", res, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].tag, vecs[i].o, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat);

        // start while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        dvd   = 32'hFFFF_FFFF;
        dvs   = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            if (n == 9) begin
                @(negedge clk);
                start = 1'b1;
                op    = 2'b11;
                dvd   = 32'd3;
                dvs   = 32'd2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        check("ign_lat", n, 34);
        check("ign_res", res, 32'hFFFF_FFFF);
        run_op("b2b_divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34);

        // flush mid-CALC
        held = res;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        dvd   = 32'd1000;
        dvs   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("flush_nodone", {31'b0, seen}, 32'd0);
        check("flush_res", res, held);

        // async reset mid-CALC, checked between clock edges
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        dvd   = 32'd77;
        dvs   = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_res", res, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("arst_nodone", {31'b0, seen}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            int          rl;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom_range(0, 1) ? $urandom() : pool[$urandom_range(0, 7)];
            rb = $urandom_range(0, 1) ? $urandom() : pool[$urandom_range(0, 7)];
            rl = 34;
            if (rb == 32'h0) rl = 1;
            if (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rl = 1;
            run_op($sformatf("rnd%0d", i), ro, ra, rb, ref_div(ro, ra, rb), rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
